// File: rtl/or8_trigger_ctrl.sv
// 8-channel OR trigger sequencer: masked edge detect, prescale, fixed-width pulse, ack/dead-time hold-off.
// Optional OR8_TRIG_SYNC_EN adds a two-flop synchronizer on hits (latency N+4 instead of N+2).
module or8_trigger_ctrl #(
  parameter int unsigned TRIG_WIDTH  = 4,
  parameter int unsigned DEAD_TIME   = 16,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [7:0]         ch_mask,
  input  logic [7:0]         hits,
  input  logic [7:0]         prescale,
  input  logic               daq_ack,
  output logic               trig_out,
  output logic [7:0]         trig_pattern,
  output logic               busy,
  output logic [COUNT_W-1:0] trig_count,
  output logic               ack_timeout
);

  localparam int unsigned TMAX_A = (TRIG_WIDTH > DEAD_TIME) ? TRIG_WIDTH : DEAD_TIME;
  localparam int unsigned TMAX   = (TMAX_A > ACK_TIMEOUT) ? TMAX_A : ACK_TIMEOUT;
  localparam int unsigned TMR_W  = (TMAX < 2) ? 1 : $clog2(TMAX);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    FIRE,
    WAIT_ACK,
    DEAD
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         hits_in;
  logic [7:0]         r1, r2;
  logic [7:0]         hit_edge;
  logic               any_edge;
  logic [7:0]         pc, pc_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [7:0]         pat_nxt;
  logic [COUNT_W-1:0] cnt_nxt;
  logic               to_nxt;

`ifdef OR8_TRIG_SYNC_EN
  logic [7:0] s1, s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= hits;
      s2 <= s1;
    end
  end

  assign hits_in = s2;
`else
  assign hits_in = hits;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1 <= '0;
      r2 <= '0;
    end else begin
      r1 <= hits_in;
      r2 <= r1;
    end
  end

  assign hit_edge = r1 & ~r2 & ch_mask;
  assign any_edge = |hit_edge;

  // One shared timer serves FIRE width, ack timeout and dead time; cleared on every exit.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    tmr_nxt   = tmr;
    pat_nxt   = trig_pattern;
    cnt_nxt   = trig_count;
    to_nxt    = ack_timeout;
    case (state)
      IDLE: begin
        pc_nxt = '0;
        if (enable) state_nxt = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (any_edge) begin
          // >= so that lowering prescale below pc fires on the next event
          if (pc >= prescale) begin
            pc_nxt    = '0;
            pat_nxt   = hit_edge;
            cnt_nxt   = trig_count + COUNT_W'(1);
            tmr_nxt   = '0;
            state_nxt = FIRE;
          end else begin
            pc_nxt = pc + 8'd1;
          end
        end
      end
      FIRE: begin
        if (tmr == TMR_W'(TRIG_WIDTH - 1)) begin
          tmr_nxt   = '0;
          state_nxt = WAIT_ACK;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      WAIT_ACK: begin
        if (daq_ack) begin
          tmr_nxt   = '0;
          state_nxt = DEAD;
        end else if (tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
          to_nxt    = 1'b1;
          tmr_nxt   = '0;
          state_nxt = DEAD;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      DEAD: begin
        if (tmr == TMR_W'(DEAD_TIME - 1)) begin
          tmr_nxt   = '0;
          state_nxt = enable ? ARMED : IDLE;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      default: begin
        tmr_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      tmr          <= '0;
      trig_out     <= 1'b0;
      trig_pattern <= '0;
      trig_count   <= '0;
      ack_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      tmr          <= tmr_nxt;
      trig_out     <= (state == FIRE);
      trig_pattern <= pat_nxt;
      trig_count   <= cnt_nxt;
      ack_timeout  <= to_nxt;
    end
  end

  assign busy = (state != IDLE) && (state != ARMED);

endmodule

// File: tb/tb_or8_trigger_ctrl.sv
// Directed self-checking bench for or8_trigger_ctrl (default parameters).
module tb_or8_trigger_ctrl;

`ifdef OR8_TRIG_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  ch_mask;
  logic [7:0]  hits;
  logic [7:0]  prescale;
  logic        daq_ack;
  logic        trig_out;
  logic [7:0]  trig_pattern;
  logic        busy;
  logic [31:0] trig_count;
  logic        ack_timeout;

  int vectors     = 0;
  int miscompares = 0;
  int exp_count   = 0;

  or8_trigger_ctrl #(
    .TRIG_WIDTH (4),
    .DEAD_TIME  (16),
    .ACK_TIMEOUT(255),
    .COUNT_W    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .ch_mask     (ch_mask),
    .hits        (hits),
    .prescale    (prescale),
    .daq_ack     (daq_ack),
    .trig_out    (trig_out),
    .trig_pattern(trig_pattern),
    .busy        (busy),
    .trig_count  (trig_count),
    .ack_timeout (ack_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle hit pattern; returns 1ns after the sampling edge N.
  task automatic pulse(input logic [7:0] b);
    hits = b;
    tick();
    hits = 8'h00;
  endtask

  task automatic wait_trig(output int lat);
    lat = 0;
    while (trig_out !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_seq(output bit ok);
    int n;
    n = 0;
    while (trig_out === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    daq_ack = 1'b1;
    tick();
    daq_ack = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic watch(input int cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (trig_out === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1; enable = 1'b0; ch_mask = 8'hFF; hits = 8'h00; prescale = 8'h00; daq_ack = 1'b0;
    #12;
    vectors++;
    if ({trig_out, trig_pattern, busy, trig_count, ack_timeout} !== 43'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %0h expected 0", {trig_out, trig_pattern, busy, trig_count, ack_timeout});
    end
    rst = 1'b0;
    tick();
    pulse(8'h08);
    watch(8, seen);
    vectors++;
    if (seen !== 1'b0 || trig_count !== 32'd0) begin
      miscompares++;
      $display("FAIL idle_no_fire: got seen=%0d count=%0d expected seen=0 count=0", seen, trig_count);
    end
  endtask

  task automatic test_basic();
    int lat, hi;
    bit ok;
    enable = 1'b1; ch_mask = 8'hFF; prescale = 8'h00;
    tick(); tick();
    pulse(8'h08);
    wait_trig(lat);
    exp_count++;
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
    end
    vectors++;
    if (trig_pattern !== 8'h08 || trig_count !== 32'(exp_count) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_state: got pat=%0h count=%0d busy=%0d expected pat=08 count=%0d busy=1",
               trig_pattern, trig_count, busy, exp_count);
    end
    hi = 0;
    while (trig_out === 1'b1 && hi < 20) begin
      tick();
      hi++;
    end
    vectors++;
    if (hi !== 4) begin
      miscompares++;
      $display("FAIL basic_width: got %0d expected 4", hi);
    end
    finish_seq(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_release: got busy=%0d expected 0", busy);
    end
  endtask

  task automatic test_mask();
    int lat;
    bit seen, ok;
    ch_mask = 8'hF0;
    pulse(8'h02);
    watch(8, seen);
    vectors++;
    if (seen !== 1'b0 || trig_count !== 32'(exp_count)) begin
      miscompares++;
      $display("FAIL mask_block: got seen=%0d count=%0d expected seen=0 count=%0d", seen, trig_count, exp_count);
    end
    pulse(8'h40);
    wait_trig(lat);
    exp_count++;
    vectors++;
    if (lat !== LAT || trig_pattern !== 8'h40 || trig_count !== 32'(exp_count)) begin
      miscompares++;
      $display("FAIL mask_pass: got lat=%0d pat=%0h count=%0d expected lat=%0d pat=40 count=%0d",
               lat, trig_pattern, trig_count, LAT, exp_count);
    end
    finish_seq(ok);
    ch_mask = 8'hFF;
  endtask

  task automatic test_prescale();
    bit seen, ok, exp_fire;
    prescale = 8'd2;
    for (int i = 0; i < 6; i++) begin
      exp_fire = (i == 2 || i == 5);
      pulse(8'h01);
      watch(6, seen);
      vectors++;
      if (seen !== exp_fire) begin
        miscompares++;
        $display("FAIL prescale_pulse%0d: got fired=%0d expected %0d", i + 1, seen, exp_fire);
      end
      if (seen) begin
        exp_count++;
        finish_seq(ok);
      end
      tick(); tick();
    end
    vectors++;
    if (trig_count !== 32'(exp_count)) begin
      miscompares++;
      $display("FAIL prescale_count: got %0d expected %0d", trig_count, exp_count);
    end
    // Two events leave pc=2; lowering prescale to 1 makes the next event fire.
    prescale = 8'd5;
    for (int i = 0; i < 2; i++) begin
      pulse(8'h01);
      watch(6, seen);
      vectors++;
      if (seen !== 1'b0) begin
        miscompares++;
        $display("FAIL prescale_live_pre%0d: got fired=1 expected 0", i);
      end
    end
    prescale = 8'd1;
    pulse(8'h01);
    watch(6, seen);
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL prescale_live_fire: got fired=0 expected 1");
    end
    if (seen) begin
      exp_count++;
      finish_seq(ok);
    end
    prescale = 8'd0;
  endtask

  task automatic test_timeout();
    int lat, n;
    bit seen, ok;
    pulse(8'h04);
    wait_trig(lat);
    exp_count++;
    repeat (257) tick();
    vectors++;
    if (ack_timeout !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: got to=%0d busy=%0d expected to=0 busy=1", ack_timeout, busy);
    end
    tick();
    vectors++;
    if (ack_timeout !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_set: got to=%0d busy=%0d expected to=1 busy=1", ack_timeout, busy);
    end
    pulse(8'h10);
    seen = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      if (trig_out === 1'b1) seen = 1'b1;
      n++;
    end
    vectors++;
    if (seen !== 1'b0 || busy !== 1'b0 || trig_count !== 32'(exp_count)) begin
      miscompares++;
      $display("FAIL dead_discard: got seen=%0d busy=%0d count=%0d expected seen=0 busy=0 count=%0d",
               seen, busy, trig_count, exp_count);
    end
    tick(); tick();
    pulse(8'h10);
    wait_trig(lat);
    exp_count++;
    vectors++;
    if (lat !== LAT || trig_pattern !== 8'h10) begin
      miscompares++;
      $display("FAIL rearm_fire: got lat=%0d pat=%0h expected lat=%0d pat=10", lat, trig_pattern, LAT);
    end
    finish_seq(ok);
    vectors++;
    if (ack_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: got %0d expected 1", ack_timeout);
    end
  endtask

  task automatic test_enable_drop();
    int lat;
    bit seen, ok;
    pulse(8'h02);
    wait_trig(lat);
    exp_count++;
    enable = 1'b0;
    finish_seq(ok);
    pulse(8'h02);
    watch(8, seen);
    vectors++;
    if (!ok || seen !== 1'b0 || trig_count !== 32'(exp_count)) begin
      miscompares++;
      $display("FAIL enable_drop: got ok=%0d seen=%0d count=%0d expected ok=1 seen=0 count=%0d",
               ok, seen, trig_count, exp_count);
    end
    enable = 1'b1;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int lat, rises, n;
    bit prev, ok;
    pulse(8'h21);
    wait_trig(lat);
    exp_count++;
    vectors++;
    if (lat !== LAT || trig_pattern !== 8'h21 || trig_count !== 32'(exp_count)) begin
      miscompares++;
      $display("FAIL multi_channel: got lat=%0d pat=%0h count=%0d expected lat=%0d pat=21 count=%0d",
               lat, trig_pattern, trig_count, LAT, exp_count);
    end
    finish_seq(ok);
    hits = 8'h01;
    daq_ack = 1'b1;
    rises = 0;
    prev = 1'b0;
    repeat (100) begin
      tick();
      if (trig_out === 1'b1 && !prev) rises++;
      prev = (trig_out === 1'b1);
    end
    hits = 8'h00;
    daq_ack = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    exp_count++;
    vectors++;
    if (rises !== 1 || trig_pattern !== 8'h01 || trig_count !== 32'(exp_count)) begin
      miscompares++;
      $display("FAIL held_once: got rises=%0d pat=%0h count=%0d expected rises=1 pat=01 count=%0d",
               rises, trig_pattern, trig_count, exp_count);
    end
  endtask

  task automatic test_reset_midpulse();
    int lat;
    bit ok;
    pulse(8'h08);
    wait_trig(lat);
    tick();
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({trig_out, trig_pattern, busy, trig_count, ack_timeout} !== 43'd0) begin
      miscompares++;
      $display("FAIL reset_midpulse: got %0h expected 0", {trig_out, trig_pattern, busy, trig_count, ack_timeout});
    end
    rst = 1'b0;
    exp_count = 0;
    tick(); tick();
    pulse(8'h08);
    wait_trig(lat);
    exp_count++;
    vectors++;
    if (lat !== LAT || trig_count !== 32'(exp_count)) begin
      miscompares++;
      $display("FAIL post_reset_latency: got lat=%0d count=%0d expected lat=%0d count=%0d",
               lat, trig_count, LAT, exp_count);
    end
    finish_seq(ok);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_prescale();
    test_timeout();
    test_enable_drop();
    test_back_to_back();
    test_reset_midpulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
